uart_alu_ctrl: RTL and testbench

Frame sequencer between the UART receiver/transmitter pair and the combinational ALU. Collects three bytes from the receiver's done-tick/data pair: operand A, operand B, opcode. Drives the ALU operand/opcode registers, captures the result and launches one transmit of the result byte. Sits at top level between uart_rx, the ALU and uart_tx.

---
 rtl/uart_alu_ctrl_pkg.sv | 24 ++
 rtl/uart_alu_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_alu_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU frame sequencer and the ALU it drives:
// FSM state encodings, default widths and opcode constants.
package uart_alu_ctrl_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: gathers operand A, operand B and opcode from uart_rx, runs the ALU
// for one cycle and hands the result to uart_tx. Optional inter-byte timeout: UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
   import uart_alu_ctrl_pkg::*;
#(
   parameter int NB_DATA        = NB_DATA_DEF,
   parameter int NB_OP          = NB_OP_DEF,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic [NB_DATA-1:0] alu_result,
   input  logic               tx_busy,
   input  logic               tx_done_tick,
   output logic [NB_DATA-1:0] alu_a,
   output logic [NB_DATA-1:0] alu_b,
   output logic [NB_OP-1:0]   alu_op,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   output logic               overrun,
   output logic               busy
);

   logic [2:0]         state_q,   state_d;
   logic [NB_DATA-1:0] alu_a_q,   alu_a_d;
   logic [NB_DATA-1:0] alu_b_q,   alu_b_d;
   logic [NB_OP-1:0]   alu_op_q,  alu_op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               overrun_q, overrun_d;
   logic               timeout_hit;
   logic               collecting;

   assign collecting = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (collecting && !rx_done_tick) cnt_d = cnt_q + 1'b1;
   end

   assign timeout_hit = collecting && !rx_done_tick &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      tx_data_d = tx_data_q;
      overrun_d = overrun_q;
      case (state_q)
         ST_WAIT_A: begin
            if (rx_done_tick) begin
               alu_a_d = rx_data;
               state_d = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (rx_done_tick) begin
               alu_b_d = rx_data;
               state_d = ST_WAIT_OP;
            end else if (timeout_hit) begin
               state_d = ST_WAIT_A;
            end
         end
         ST_WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data[NB_OP-1:0];
               state_d  = ST_EXEC;
            end else if (timeout_hit) begin
               state_d = ST_WAIT_A;
            end
         end
         ST_EXEC: begin
            tx_data_d = alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            if (!tx_busy) state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_done_tick) state_d = ST_WAIT_A;
         end
         default: state_d = ST_WAIT_A;
      endcase
      // Bytes arriving while the frame is being executed or sent are lost.
      if (rx_done_tick && busy) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q   <= ST_WAIT_A;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         tx_data_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         tx_data_q <= tx_data_d;
         overrun_q <= overrun_d;
      end
   end

   assign busy     = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
   assign tx_start = (state_q == ST_SEND) && !tx_busy;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign tx_data  = tx_data_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed self-checking bench for uart_alu_ctrl with a behavioural ALU model.
// The timeout scenario runs only when UART_ALU_CTRL_TIMEOUT_EN is defined.
module tb_uart_alu_ctrl;
   import uart_alu_ctrl_pkg::*;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 1000000;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic [7:0] alu_result;
   logic       tx_busy;
   logic       tx_done_tick;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   uart_alu_ctrl #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .alu_result   (alu_result),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .overrun      (overrun),
      .busy         (busy)
   );

   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         OP_ADD: alu_result = alu_a + alu_b;
         OP_SUB: alu_result = alu_a - alu_b;
         OP_AND: alu_result = alu_a & alu_b;
         OP_OR:  alu_result = alu_a | alu_b;
         OP_XOR: alu_result = alu_a ^ alu_b;
         OP_NOR: alu_result = ~(alu_a | alu_b);
         OP_SRA: alu_result = $signed(alu_a) >>> alu_b;
         OP_SRL: alu_result = alu_a >> alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      step(1);
      rx_done_tick = 1'b0;
   endtask

   task automatic pulse_tx_done();
      tx_done_tick = 1'b1;
      step(1);
      tx_done_tick = 1'b0;
   endtask

   initial begin
      int pulses;
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      tx_busy      = 1'b0;
      tx_done_tick = 1'b0;
      step(2);
      check("rst_alu_a",    alu_a,    0);
      check("rst_alu_b",    alu_b,    0);
      check("rst_alu_op",   alu_op,   0);
      check("rst_tx_data",  tx_data,  0);
      check("rst_tx_start", tx_start, 0);
      check("rst_overrun",  overrun,  0);
      check("rst_busy",     busy,     0);
      reset = 1'b0;
      step(1);

      // Frame 1: 5 + 3, transmitter idle
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h20);
      check("f1_alu_a",       alu_a,    8'h05);
      check("f1_alu_b",       alu_b,    8'h03);
      check("f1_alu_op",      alu_op,   6'h20);
      check("f1_exec_busy",   busy,     1);
      check("f1_exec_start",  tx_start, 0);
      step(1);
      check("f1_send_start",  tx_start, 1);
      check("f1_tx_data",     tx_data,  8'h08);
      step(1);
      check("f1_wtx_start",   tx_start, 0);
      check("f1_wtx_busy",    busy,     1);
      pulse_tx_done();
      check("f1_idle_busy",   busy,     0);

      // Frame 2: stray tx_done in WAIT_B ignored, transmitter busy at SEND
      send_byte(8'h10);
      pulse_tx_done();
      send_byte(8'h04);
      check("f2_alu_b",       alu_b,    8'h04);
      tx_busy = 1'b1;
      send_byte(8'h22);
      step(1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_start) pulses++;
         step(1);
      end
      check("f2_held_pulses", pulses,   0);
      check("f2_held_busy",   busy,     1);
      tx_busy = 1'b0;
      #1;
      check("f2_release",     tx_start, 1);
      check("f2_tx_data",     tx_data,  8'h0C);
      step(1);
      check("f2_one_pulse",   tx_start, 0);
      check("f2_tx_data_hold", tx_data, 8'h0C);
      pulse_tx_done();

      // Frame 3: overrun byte during WAIT_TX
      send_byte(8'h07);
      send_byte(8'h02);
      send_byte(8'h25);
      step(2);
      check("f3_pre_overrun", overrun,  0);
      send_byte(8'hAA);
      check("f3_overrun",     overrun,  1);
      check("f3_alu_a_kept",  alu_a,    8'h07);
      check("f3_still_busy",  busy,     1);
      check("f3_tx_data",     tx_data,  8'h07);
      pulse_tx_done();

      // Frame 4: normal frame with overrun still sticky
      send_byte(8'h0F);
      send_byte(8'hF0);
      send_byte(8'h24);
      check("f4_alu_a",       alu_a,    8'h0F);
      check("f4_alu_b",       alu_b,    8'hF0);
      check("f4_alu_op",      alu_op,   6'h24);
      check("f4_overrun",     overrun,  1);
      step(1);
      check("f4_send_start",  tx_start, 1);
      check("f4_tx_data",     tx_data,  8'h00);
      step(1);

      // Simultaneous rx and tx_done in WAIT_TX: byte dropped, back to WAIT_A
      rx_data      = 8'h55;
      rx_done_tick = 1'b1;
      tx_done_tick = 1'b1;
      step(1);
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      check("sim_busy",       busy,     0);
      check("sim_alu_a",      alu_a,    8'h0F);
      send_byte(8'h11);
      check("sim_next_a",     alu_a,    8'h11);

      // Reset mid-frame after two bytes
      send_byte(8'h22);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("mrst_alu_a",     alu_a,    0);
      check("mrst_alu_b",     alu_b,    0);
      check("mrst_tx_data",   tx_data,  0);
      check("mrst_overrun",   overrun,  0);
      check("mrst_busy",      busy,     0);
      send_byte(8'h09);
      send_byte(8'h06);
      send_byte(8'h26);
      check("f5_alu_a",       alu_a,    8'h09);
      check("f5_alu_b",       alu_b,    8'h06);
      step(1);
      check("f5_tx_data",     tx_data,  8'h0F);
      step(1);
      pulse_tx_done();

      // Opcode upper bits discarded
      send_byte(8'h0C);
      send_byte(8'h0A);
      send_byte(8'hE6);
      check("f6_alu_op",      alu_op,   6'h26);
      step(1);
      check("f6_tx_data",     tx_data,  8'h06);
      step(1);
      pulse_tx_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
      // Two bytes then silence: frame abandoned, next three bytes form a frame
      send_byte(8'h01);
      send_byte(8'h02);
      pulses = 0;
      for (int i = 0; i < 110; i++) begin
         if (tx_start) pulses++;
         step(1);
      end
      check("tmo_no_start",   pulses,   0);
      check("tmo_busy",       busy,     0);
      check("tmo_partial_a",  alu_a,    8'h01);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h20);
      check("tmo_alu_a",      alu_a,    8'h03);
      check("tmo_alu_b",      alu_b,    8'h04);
      step(1);
      check("tmo_tx_data",    tx_data,  8'h07);
      check("tmo_start",      tx_start, 1);
      step(1);
      pulse_tx_done();
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
